// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter feeding the write side of an async FIFO.
// Grants only when the whole burst fits in the FIFO's free space.
module afifo_wr_arb #(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 5
) (
   input  logic                       wrclk,
   input  logic                       wrrstn,
   input  logic [NREQ-1:0]            src_req,
   input  logic [NREQ*LEN_WIDTH-1:0]  src_len,
   input  logic [NREQ*DATA_WIDTH-1:0] src_data,
   output logic [NREQ-1:0]            src_ack,
   output logic [NREQ-1:0]            src_done,
   output logic                       fifo_wrreq,
   output logic [DATA_WIDTH-1:0]      fifo_wrdata,
   input  logic                       fifo_wrfull,
   input  logic [ADDR_WIDTH:0]        fifo_wr_avail,
   output logic                       busy,
   output logic [$clog2(NREQ)-1:0]    grant_id
);

   localparam int GW = $clog2(NREQ);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST,
      S_SETTLE
   } state_t;

   state_t               state;
   logic [GW-1:0]        rr_ptr;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic                 settle_cnt;

   logic [NREQ-1:0]      elig;
   logic                 win_vld;
   logic [GW-1:0]        win_idx;
   logic [GW-1:0]        nxt_ptr;
   logic [LEN_WIDTH-1:0] win_len;
   logic                 accept;
   logic                 last;
   int                   idx;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = src_req[i]
                 && (src_len[i*LEN_WIDTH +: LEN_WIDTH] != '0)
                 && (32'(src_len[i*LEN_WIDTH +: LEN_WIDTH])
                     <= 32'(fifo_wr_avail));
      end
   end

   // Scan starting at rr_ptr; first eligible index wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_vld && elig[idx]) begin
            win_vld = 1'b1;
            win_idx = GW'(idx);
         end
      end
   end

   assign nxt_ptr = (win_idx == GW'(NREQ-1)) ? '0 : win_idx + 1'b1;
   assign win_len = src_len[win_idx*LEN_WIDTH +: LEN_WIDTH];

   assign accept      = (state == S_BURST) && !fifo_wrfull;
   assign last        = accept && (beat_cnt == LEN_WIDTH'(1));
   assign fifo_wrreq  = (state == S_BURST);
   assign fifo_wrdata = src_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign src_ack     = accept ? (ONE << grant_id) : '0;
   assign src_done    = last ? (ONE << grant_id) : '0;
   assign busy        = (state != S_IDLE);

   always_ff @(posedge wrclk) begin
      if (!wrrstn) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         grant_id   <= '0;
         beat_cnt   <= '0;
         settle_cnt <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  state    <= S_BURST;
                  grant_id <= win_idx;
                  beat_cnt <= win_len;
                  rr_ptr   <= nxt_ptr;
               end
            end
            S_BURST: begin
               if (accept) begin
                  beat_cnt <= beat_cnt - 1'b1;
                  if (last) begin
                     state      <= S_SETTLE;
                     settle_cnt <= 1'b0;
                  end
               end
            end
            // Two cycles so fifo_wr_avail reflects the finished burst.
            S_SETTLE: begin
               settle_cnt <= 1'b1;
               if (settle_cnt) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Bench for afifo_wr_arb: directed scenarios then random traffic,
// each cycle compared against a transaction-level model.
module tb_afifo_wr_arb;

   localparam int NREQ = 4;
   localparam int DW   = 64;
   localparam int AW   = 12;
   localparam int LW   = 5;
   localparam int GW   = $clog2(NREQ);

   logic               wrclk = 1'b0;
   logic               wrrstn;
   logic [NREQ-1:0]    src_req;
   logic [NREQ*LW-1:0] src_len;
   logic [NREQ*DW-1:0] src_data;
   logic [NREQ-1:0]    src_ack;
   logic [NREQ-1:0]    src_done;
   logic               fifo_wrreq;
   logic [DW-1:0]      fifo_wrdata;
   logic               fifo_wrfull;
   logic [AW:0]        fifo_wr_avail;
   logic               busy;
   logic [GW-1:0]      grant_id;

   afifo_wr_arb #(
      .NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .wrclk(wrclk), .wrrstn(wrrstn),
      .src_req(src_req), .src_len(src_len), .src_data(src_data),
      .src_ack(src_ack), .src_done(src_done),
      .fifo_wrreq(fifo_wrreq), .fifo_wrdata(fifo_wrdata),
      .fifo_wrfull(fifo_wrfull), .fifo_wr_avail(fifo_wr_avail),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 wrclk = ~wrclk;

   int n_tot = 0;
   int n_pass = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Model: owner, beats left, settle cycles left, next search start.
   int m_gid = 0;
   int m_left = 0;
   int m_settle = 0;
   int m_ptr = 0;

   int n_wrreq = 0;
   int n_ack = 0;
   int n_done = 0;
   int cyc = 0;
   bit prev_wrreq = 0;
   int glog[$];
   int gtime[$];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int lenof(int i);
      return int'(src_len[i*LW +: LW]);
   endfunction

   task automatic set_len(int i, int v);
      src_len[i*LW +: LW] = LW'(v);
   endtask

   task automatic cycle();
      bit inb, acc;
      logic [NREQ-1:0] ea, ed;
      for (int i = 0; i < NREQ; i++) src_data[i*DW +: DW] = {$urandom, $urandom};
      #1;
      inb = (m_left > 0);
      acc = inb && !fifo_wrfull;
      ea  = acc ? (NREQ'(1) << m_gid) : '0;
      ed  = (acc && m_left == 1) ? (NREQ'(1) << m_gid) : '0;
      if (chk_en) begin
         chk("wrreq", 64'(fifo_wrreq), 64'(inb));
         chk("ack", 64'(src_ack), 64'(ea));
         chk("done", 64'(src_done), 64'(ed));
         chk("busy", 64'(busy), 64'(inb || m_settle > 0));
         chk("gid", 64'(grant_id), 64'(m_gid));
         if (inb) chk("data", fifo_wrdata, src_data[m_gid*DW +: DW]);
      end
      if (fifo_wrreq) n_wrreq++;
      if (|src_ack) n_ack++;
      if (|src_done) n_done++;
      if (fifo_wrreq && !prev_wrreq) begin
         glog.push_back(int'(grant_id));
         gtime.push_back(cyc);
      end
      prev_wrreq = fifo_wrreq;
      cyc++;
      @(posedge wrclk);
      if (!wrrstn) begin
         m_left = 0; m_settle = 0; m_ptr = 0; m_gid = 0;
      end else if (m_left > 0) begin
         if (!fifo_wrfull) begin
            m_left--;
            if (m_left == 0) m_settle = 2;
         end
      end else if (m_settle > 0) begin
         m_settle--;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            int l = lenof(i);
            if (src_req[i] && l > 0 && l <= int'(fifo_wr_avail)) begin
               m_gid = i; m_left = l; m_ptr = (i + 1) % NREQ;
               break;
            end
         end
      end
      @(negedge wrclk);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      wrrstn = 1'b0;
      cycle();
      wrrstn = 1'b1;
   endtask

   initial begin
      wrrstn = 1'b0;
      src_req = '0;
      src_len = '0;
      src_data = '0;
      fifo_wrfull = 1'b0;
      fifo_wr_avail = 13'd100;
      @(negedge wrclk);
      do_reset();
      chk_en = 1;
      run(2);

      // Single requester, len 4
      n_wrreq = 0; n_ack = 0; n_done = 0;
      src_req = 4'b0001; set_len(0, 4);
      cycle();
      src_req = '0;
      run(8);
      chk("single_wrreq", 64'(n_wrreq), 64'd4);
      chk("single_acks", 64'(n_ack), 64'd4);
      chk("single_done", 64'(n_done), 64'd1);

      // Round robin, all len 1
      do_reset();
      glog.delete(); gtime.delete();
      for (int i = 0; i < NREQ; i++) set_len(i, 1);
      src_req = '1;
      run(20);
      src_req = '0;
      run(4);
      chk("rr_count", 64'(glog.size() >= 5), 64'd1);
      if (glog.size() >= 5) begin
         for (int i = 0; i < 5; i++) chk("rr_id", 64'(glog[i]), 64'(i % NREQ));
         for (int i = 1; i < 5; i++) chk("rr_gap", 64'(gtime[i] - gtime[i-1]), 64'd4);
      end

      // Avail gating
      do_reset();
      src_req = 4'b0001; set_len(0, 4); fifo_wr_avail = 13'd3;
      n_wrreq = 0;
      run(5);
      chk("gate_none", 64'(n_wrreq), 64'd0);
      fifo_wr_avail = 13'd4;
      cycle();
      src_req = '0;
      #1 chk("gate_start", 64'(fifo_wrreq), 64'd1);
      run(7);
      glog.delete();
      src_req = 4'b0011; set_len(1, 2); fifo_wr_avail = 13'd3;
      cycle();
      src_req = '0;
      run(5);
      chk("gate_req1", 64'(glog.size() > 0 ? glog[0] : -1), 64'd1);

      // Full stall during beat 2
      n_wrreq = 0; n_ack = 0;
      fifo_wr_avail = 13'd100;
      src_req = 4'b0001; set_len(0, 4);
      cycle();
      src_req = '0;
      cycle();
      fifo_wrfull = 1'b1;
      run(3);
      fifo_wrfull = 1'b0;
      run(6);
      chk("stall_cycles", 64'(n_wrreq), 64'd7);
      chk("stall_acks", 64'(n_ack), 64'd4);

      // Reset mid-burst
      n_done = 0;
      src_req = 4'b0100; set_len(2, 4);
      cycle();
      src_req = '0;
      cycle();
      wrrstn = 1'b0;
      cycle();
      wrrstn = 1'b1;
      chk("rst_nodone", 64'(n_done), 64'd0);
      glog.delete();
      for (int i = 0; i < NREQ; i++) set_len(i, 2);
      src_req = '1;
      cycle();
      src_req = '0;
      run(5);
      chk("rst_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);

      // Zero length never granted
      n_wrreq = 0;
      src_req = 4'b0100; set_len(2, 0);
      run(15);
      src_req = '0;
      chk("zero_len", 64'(n_wrreq), 64'd0);

      // Random traffic
      for (int t = 0; t < 600; t++) begin
         src_req = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(0, 6));
         fifo_wr_avail = 13'($urandom_range(0, 12));
         fifo_wrfull = ($urandom_range(0, 3) == 0);
         wrrstn = ($urandom_range(0, 49) != 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/afifo_wr_arb.md
AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, FIFO data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, FIFO address width; wr_avail is ADDR_WIDTH+1 bits.
REQ-004 SHALL have parameter LEN_WIDTH, default 5, burst-length field width; legal lengths are 1..16.
REQ-005 SHALL have port wrclk  in  1  single clock, rising edge; same domain as the FIFO write side.
REQ-006 SHALL have port wrrstn  in  1  reset; one clock, reset is synchronous and active-low.
REQ-007 SHALL have port src_req  in  NREQ  per-requester burst request, level.
REQ-008 SHALL have port src_len  in  NREQ*LEN_WIDTH  per-requester burst length; slice i is [i*LEN_WIDTH +: LEN_WIDTH].
REQ-009 SHALL have port src_data  in  NREQ*DATA_WIDTH  per-requester current beat data.
REQ-010 SHALL have port src_ack  out  NREQ  beat accepted; requester advances src_data on the next cycle.
REQ-011 SHALL have port src_done  out  NREQ  one-cycle pulse coincident with the last accepted beat.
REQ-012 SHALL have port fifo_wrreq  out  1  FIFO write request.
REQ-013 SHALL have port fifo_wrdata  out  DATA_WIDTH  FIFO write data.
REQ-014 SHALL have port fifo_wrfull  in  1  FIFO full flag.
REQ-015 SHALL have port fifo_wr_avail  in  ADDR_WIDTH+1  FIFO free-entry count.
REQ-016 SHALL have port busy  out  1  high in any non-IDLE state.
REQ-017 SHALL have port grant_id  out  clog2(NREQ)  index of the current or most recent winner.

Function
REQ-018 SHALL implement states IDLE, BURST and SETTLE.
REQ-019 In IDLE, requester i SHALL be eligible iff src_req[i]=1, its len is nonzero, and fifo_wr_avail >= len (unsigned compare, len zero-extended).
REQ-020 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo NREQ; the first eligible index wins.
REQ-021 On a win, the block SHALL register grant_id, load beat_cnt with len, set rr_ptr to (winner+1) mod NREQ, and enter BURST on the next cycle.
REQ-022 Ineligible requesters SHALL NOT block eligible ones; with no eligible requester the block SHALL stay in IDLE.
REQ-023 In BURST, fifo_wrreq SHALL be 1 and fifo_wrdata SHALL equal src_data slice grant_id.
REQ-024 A beat SHALL be accepted iff state=BURST and fifo_wrfull=0; src_ack[grant_id] SHALL equal the accept signal combinationally, and all other bits of src_ack SHALL be 0.
REQ-025 beat_cnt SHALL decrement only on an accepted beat; while fifo_wrfull=1, beat_cnt and state SHALL be held.
REQ-026 On an accepted beat with beat_cnt=1, src_done[grant_id] SHALL pulse and the next state SHALL be SETTLE.
REQ-027 SETTLE SHALL last exactly 2 cycles, covering the registered-count lag of fifo_wr_avail, then return to IDLE.
REQ-028 src_req and src_len SHALL be ignored outside IDLE; a burst SHALL complete even if the requester deasserts src_req.
REQ-029 Latency SHALL be: request sampled in IDLE at cycle N gives first fifo_wrreq at N+1; minimum grant-to-grant period is len+3 cycles.
REQ-030 Outside BURST, fifo_wrreq, src_ack and src_done SHALL be 0; fifo_wrdata is don't-care.

Reset
REQ-031 With wrrstn=0 at a rising edge, the block SHALL enter IDLE, with rr_ptr=0, grant_id=0, beat_cnt=0 and busy=0.
REQ-032 Reset SHALL take priority over any in-progress burst; fifo_wrreq SHALL be 0 in the first cycle after the reset edge, and no src_done is issued for the aborted burst.

Verification
REQ-033 Single requester: src_req[0]=1, len=4, avail=100 -> fifo_wrreq high 4 consecutive cycles; src_ack[0] on each; src_done[0] on the 4th; busy drops 2 cycles later.
REQ-034 Round-robin: all four requesters with len=1 held for 20 cycles -> grant_id sequence 0,1,2,3,0, each grant 4 cycles apart.
REQ-035 Avail gating: req0 len=4 with avail=3 -> no grant; raise avail to 4 -> BURST starts the next cycle; req1 len=2 at avail=3 is granted first.
REQ-036 Full stall: fifo_wrfull=1 for 3 cycles during beat 2 of 4 -> fifo_wrreq stays 1, src_ack=0, 7 total BURST cycles, 4 acks.
REQ-037 Reset mid-burst: wrrstn=0 during beat 2 -> next cycle busy=0, fifo_wrreq=0, no src_done; the first grant after reset goes to requester 0 when all request.
REQ-038 Zero length: src_req[2]=1 with len=0 and no other requests -> the block stays IDLE indefinitely.
